// File: rtl/imm_field_encoder_if.sv
// imm_field_encoder_if: request/result bundle for imm_field_encoder.
// master drives start/mode/value; slave returns busy/done/ok/field/u_bit.
interface imm_field_encoder_if;
  logic        start;
  logic [1:0]  mode;
  logic [31:0] value;
  logic        busy;
  logic        done;
  logic        ok;
  logic [23:0] field;
  logic        u_bit;

  modport master (
    output start,
    output mode,
    output value,
    input  busy,
    input  done,
    input  ok,
    input  field,
    input  u_bit
  );

  modport slave (
    input  start,
    input  mode,
    input  value,
    output busy,
    output done,
    output ok,
    output field,
    output u_bit
  );
endinterface

// File: rtl/imm_field_encoder.sv
// imm_field_encoder: operand -> rotated imm8 / off12 / imm24 fields.
// clk, reset (sync, active-high), bus (slave): start/mode/value in,
// busy/done/ok/field/u_bit out; results held until next done.
module imm_field_encoder #(
  parameter int ROT_STEPS = 16
) (
  input  logic               clk,
  input  logic               reset,
  imm_field_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_e;

  localparam logic [1:0] MODE_DP = 2'b00;
  localparam logic [1:0] MODE_LS = 2'b01;
  localparam logic [1:0] MODE_BR = 2'b10;

  localparam logic [3:0] ROT_LAST = 4'(ROT_STEPS - 1);

  state_e      state_q, state_d;
  logic [3:0]  rot_q, rot_d;
  logic [31:0] value_q, value_d;
  logic [1:0]  mode_q, mode_d;
  logic [23:0] field_q, field_d;
  logic        ok_q, ok_d;
  logic        u_bit_q, u_bit_d;

  logic [4:0]  sh;
  logic [31:0] cand;
  logic        dp_hit;
  logic [31:0] mag;
  logic        ls_ok;
  logic        br_ok;

  // Rotate-left by 2*rot: the decoder rotates imm8 right by the
  // same amount, so a clear upper 24 bits here means a valid field.
  always_comb begin
    sh     = {rot_q, 1'b0};
    cand   = (value_q << sh)
           | (value_q >> (6'd32 - {1'b0, sh}));
    dp_hit = (cand[31:8] == 24'd0);
  end

  // 0x80000000 negates to itself; as an unsigned magnitude
  // it is far above 4095, so it is rejected naturally.
  always_comb begin
    mag   = value_q[31] ? (~value_q + 32'd1) : value_q;
    ls_ok = (mag < 32'd4096);
  end

  // Signed range [-2^25, 2^25-1] means bits 31..25 all match;
  // with word alignment the top becomes 2^25-4.
  always_comb begin
    br_ok = (value_q[1:0] == 2'b00)
         && (value_q[31:25] == {7{value_q[25]}});
  end

  always_comb begin
    state_d = state_q;
    rot_d   = rot_q;
    value_d = value_q;
    mode_d  = mode_q;
    field_d = field_q;
    ok_d    = ok_q;
    u_bit_d = u_bit_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          value_d = bus.value;
          mode_d  = bus.mode;
          rot_d   = 4'd0;
          state_d = SEARCH;
        end
      end

      SEARCH: begin
        unique case (mode_q)
          MODE_DP: begin
            u_bit_d = 1'b0;
            if (dp_hit) begin
              field_d = {12'd0, rot_q, cand[7:0]};
              ok_d    = 1'b1;
              state_d = DONE;
            end else if (rot_q == ROT_LAST) begin
              field_d = 24'd0;
              ok_d    = 1'b0;
              state_d = DONE;
            end else begin
              rot_d = rot_q + 4'd1;
            end
          end

          MODE_LS: begin
            u_bit_d = ~value_q[31];
            ok_d    = ls_ok;
            field_d = ls_ok ? {12'd0, mag[11:0]}
                            : 24'd0;
            state_d = DONE;
          end

          MODE_BR: begin
            u_bit_d = 1'b0;
            ok_d    = br_ok;
            field_d = br_ok ? value_q[25:2] : 24'd0;
            state_d = DONE;
          end

          default: begin
            u_bit_d = 1'b0;
            ok_d    = 1'b0;
            field_d = 24'd0;
            state_d = DONE;
          end
        endcase
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rot_q   <= 4'd0;
      value_q <= 32'd0;
      mode_q  <= 2'd0;
      field_q <= 24'd0;
      ok_q    <= 1'b0;
      u_bit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rot_q   <= rot_d;
      value_q <= value_d;
      mode_q  <= mode_d;
      field_q <= field_d;
      ok_q    <= ok_d;
      u_bit_q <= u_bit_d;
    end
  end

  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = (state_q == DONE);
  assign bus.ok    = ok_q;
  assign bus.field = field_q;
  assign bus.u_bit = u_bit_q;

endmodule

// File: tb/tb_imm_field_encoder.sv
// tb_imm_field_encoder: directed + random checks of imm_field_encoder
// against a behavioural model and an independent field decoder.
module tb_imm_field_encoder;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  imm_field_encoder_if bus ();

  imm_field_encoder #(
    .ROT_STEPS (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  int          r_lat;
  int          r_gaps;
  logic        r_c1_busy;
  logic        r_c1_ok;
  logic [23:0] r_c1_field;
  logic        r_ok;
  logic [23:0] r_field;
  logic        r_u;
  logic        r_p_busy;
  logic        r_p_done;
  time         r_tdone;

  function automatic logic [31:0] rotr(
    input logic [31:0] x, input int s);
    logic [63:0] d;
    d = {x, x} >> s;
    return d[31:0];
  endfunction

  // Reference: search smallest rotation / range checks via
  // signed 64-bit arithmetic.
  function automatic void ref_model(
    input  logic [1:0]  m,
    input  logic [31:0] v,
    output logic        e_ok,
    output logic [23:0] e_field,
    output logic        e_u,
    output int          e_lat);
    longint sv;
    longint mg;
    logic [63:0] d;
    logic [31:0] c;
    e_ok = 1'b0;
    e_field = 24'd0;
    e_u = 1'b0;
    e_lat = 2;
    sv = longint'($signed(v));
    case (m)
      2'b00: begin
        e_lat = 17;
        d = {v, v};
        for (int r = 0; r < 16; r++) begin
          c = d[63 - 2*r -: 32];
          if (c[31:8] == 24'd0) begin
            e_ok = 1'b1;
            e_field = {12'd0, 4'(r), c[7:0]};
            e_lat = r + 2;
            break;
          end
        end
      end
      2'b01: begin
        mg = (sv < 0) ? -sv : sv;
        e_u = (sv >= 0);
        e_ok = (mg < 4096);
        if (e_ok) e_field = 24'(mg);
      end
      2'b10: begin
        e_ok = (sv % 4 == 0) && (sv >= -(64'sd1 << 25))
            && (sv <= (64'sd1 << 25) - 4);
        if (e_ok) e_field = 24'(sv / 4);
      end
      default: ;
    endcase
  endfunction

  // Datapath-side decode of a reported field.
  function automatic logic [31:0] decode(
    input logic [1:0] m, input logic [23:0] f, input logic u);
    logic [31:0] x;
    case (m)
      2'b00: return rotr({24'd0, f[7:0]}, 2 * int'(f[11:8]));
      2'b01: begin
        x = {20'd0, f[11:0]};
        return u ? x : (~x + 32'd1);
      end
      default: return {{6{f[23]}}, f, 2'b00};
    endcase
  endfunction

  task automatic run_op(
    input logic [1:0] m, input logic [31:0] v, input bit post);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = m;
    bus.value = v;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.mode  = 2'($urandom);
    bus.value = $urandom;
    r_lat = -1;
    r_gaps = 0;
    r_p_busy = 1'b0;
    r_p_done = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        r_c1_busy  = bus.busy;
        r_c1_ok    = bus.ok;
        r_c1_field = bus.field;
      end
      if (!bus.busy) r_gaps++;
      if (bus.done) begin
        r_lat   = cyc;
        r_ok    = bus.ok;
        r_field = bus.field;
        r_u     = bus.u_bit;
        r_tdone = $time;
        break;
      end
    end
    if (post) begin
      @(negedge clk);
      r_p_busy = bus.busy;
      r_p_done = bus.done;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.mode = 2'b00;
    bus.value = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({bus.busy, bus.done, bus.ok, bus.u_bit} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_flags got %b exp 0000",
        {bus.busy, bus.done, bus.ok, bus.u_bit});
    end
    n_vec++;
    if (bus.field !== 24'd0) begin
      n_err++;
      $display("FAIL reset_field got %h exp 0", bus.field);
    end
    reset = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_prio busy got %b exp 0", bus.busy);
    end
  endtask

  task automatic test_mode00();
    logic [31:0] tv [5] = '{32'h0000_00FF, 32'hFF00_0000,
      32'h0000_03FC, 32'h0000_0101, 32'h0};
    int          tl [5] = '{2, 6, 17, 17, 2};
    logic        tk [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [23:0] tf [5] = '{24'h0000FF, 24'h0004FF,
      24'h000FFF, 24'h0, 24'h0};
    run_op(2'b01, 32'd4095, 1'b0);
    for (int i = 0; i < 5; i++) begin
      run_op(2'b00, tv[i], 1'b1);
      n_vec++;
      if (r_lat !== tl[i] || r_ok !== tk[i] || r_field !== tf[i]
          || r_u !== 1'b0) begin
        n_err++;
        $display("FAIL m00 v=%h got lat=%0d ok=%b f=%h u=%b exp lat=%0d ok=%b f=%h u=0",
          tv[i], r_lat, r_ok, r_field, r_u, tl[i], tk[i], tf[i]);
      end
      n_vec++;
      if (r_c1_busy !== 1'b1 || r_gaps !== 0
          || r_p_busy !== 1'b0 || r_p_done !== 1'b0) begin
        n_err++;
        $display("FAIL m00_busy v=%h got c1=%b gaps=%0d pb=%b pd=%b exp 1 0 0 0",
          tv[i], r_c1_busy, r_gaps, r_p_busy, r_p_done);
      end
    end
  endtask

  task automatic test_mode01();
    logic [31:0] tv [4] = '{32'hFFFF_FFFC, 32'd4095,
      32'd4096, 32'h8000_0000};
    logic        tk [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [23:0] tf [4] = '{24'h4, 24'hFFF, 24'h0, 24'h0};
    logic        tu [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      run_op(2'b01, tv[i], 1'b0);
      n_vec++;
      if (r_lat !== 2 || r_ok !== tk[i] || r_field !== tf[i]
          || r_u !== tu[i]) begin
        n_err++;
        $display("FAIL m01 v=%h got lat=%0d ok=%b f=%h u=%b exp lat=2 ok=%b f=%h u=%b",
          tv[i], r_lat, r_ok, r_field, r_u, tk[i], tf[i], tu[i]);
      end
    end
  endtask

  task automatic test_mode10();
    logic [31:0] tv [5] = '{32'hFFFF_FFF8, 32'h01FF_FFFC,
      32'h0200_0000, 32'd6, 32'hFE00_0000};
    logic        tk [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [23:0] tf [5] = '{24'hFFFFFE, 24'h7FFFFF,
      24'h0, 24'h0, 24'h800000};
    run_op(2'b01, 32'd5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      run_op(2'b10, tv[i], 1'b0);
      n_vec++;
      if (r_lat !== 2 || r_ok !== tk[i] || r_field !== tf[i]
          || r_u !== 1'b0) begin
        n_err++;
        $display("FAIL m10 v=%h got lat=%0d ok=%b f=%h u=%b exp lat=2 ok=%b f=%h u=0",
          tv[i], r_lat, r_ok, r_field, r_u, tk[i], tf[i]);
      end
    end
  endtask

  task automatic test_mode11_and_hold();
    run_op(2'b01, 32'd4095, 1'b0);
    run_op(2'b11, 32'd8, 1'b1);
    n_vec++;
    if (r_c1_ok !== 1'b1 || r_c1_field !== 24'hFFF) begin
      n_err++;
      $display("FAIL hold got ok=%b f=%h exp ok=1 f=fff",
        r_c1_ok, r_c1_field);
    end
    n_vec++;
    if (r_lat !== 2 || r_ok !== 1'b0 || r_field !== 24'd0
        || r_u !== 1'b0 || r_p_done !== 1'b0) begin
      n_err++;
      $display("FAIL m11 got lat=%0d ok=%b f=%h u=%b pd=%b exp 2 0 0 0 0",
        r_lat, r_ok, r_field, r_u, r_p_done);
    end
  endtask

  task automatic test_start_ignored();
    int dones = 0;
    int dcyc = -1;
    int late_busy = 0;
    logic [23:0] dfield = 24'd0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode = 2'b00;
    bus.value = 32'h0000_03FC;
    @(posedge clk);
    #1;
    for (int cyc = 1; cyc <= 17; cyc++) begin
      bus.mode = 2'($urandom);
      bus.value = $urandom;
      @(negedge clk);
      if (bus.done) begin
        dones++;
        dcyc = cyc;
        dfield = bus.field;
      end
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int cyc = 18; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (bus.done) dones++;
      if (bus.busy) late_busy++;
    end
    n_vec++;
    if (dones !== 1 || dcyc !== 17 || dfield !== 24'hFFF
        || late_busy !== 0) begin
      n_err++;
      $display("FAIL start_ignored got dones=%0d cyc=%0d f=%h busy=%0d exp 1 17 fff 0",
        dones, dcyc, dfield, late_busy);
    end
  endtask

  task automatic test_reset_abort();
    int dones = 0;
    run_op(2'b01, 32'd4095, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode = 2'b00;
    bus.value = 32'h0000_0101;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({bus.busy, bus.done, bus.ok, bus.u_bit} !== 4'b0
        || bus.field !== 24'd0) begin
      n_err++;
      $display("FAIL abort_clear got b=%b d=%b ok=%b u=%b f=%h exp all 0",
        bus.busy, bus.done, bus.ok, bus.u_bit, bus.field);
    end
    repeat (20) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    n_vec++;
    if (dones !== 0) begin
      n_err++;
      $display("FAIL abort_done got %0d exp 0", dones);
    end
  endtask

  task automatic test_back_to_back();
    time t0;
    run_op(2'b01, 32'd12, 1'b0);
    t0 = r_tdone;
    run_op(2'b10, 32'd16, 1'b0);
    n_vec++;
    if (r_lat !== 2 || (r_tdone - t0) !== 30 || r_field !== 24'd4) begin
      n_err++;
      $display("FAIL b2b_short got lat=%0d dt=%0t f=%h exp 2 30 4",
        r_lat, r_tdone - t0, r_field);
    end
    t0 = r_tdone;
    run_op(2'b00, 32'hFF00_0000, 1'b0);
    t0 = r_tdone - t0;
    run_op(2'b11, 32'd0, 1'b0);
    n_vec++;
    if (t0 !== 70 || r_lat !== 2) begin
      n_err++;
      $display("FAIL b2b_rot got dt=%0t lat=%0d exp 70 2", t0, r_lat);
    end
  endtask

  task automatic test_random(input logic [1:0] m, input int n);
    logic [31:0] v;
    logic [31:0] s;
    logic [25:0] v26;
    logic        e_ok;
    logic [23:0] e_field;
    logic        e_u;
    int          e_lat;
    int          pick;
    for (int i = 0; i < n; i++) begin
      pick = $urandom_range(0, 3);
      v = $urandom;
      if (m == 2'b00 && pick != 0) begin
        v = rotr({24'd0, 8'($urandom)}, 2 * $urandom_range(0, 15));
      end else if (m == 2'b01 && pick != 0) begin
        s = 32'($urandom_range(0, 8191));
        v = (pick == 1) ? ~s : s;
      end else if (m == 2'b10 && pick != 0) begin
        v26 = 26'($urandom);
        if (pick != 3) v26[1:0] = 2'b00;
        v = {{6{v26[25]}}, v26};
      end
      ref_model(m, v, e_ok, e_field, e_u, e_lat);
      run_op(m, v, 1'b0);
      n_vec++;
      if (r_lat !== e_lat || r_ok !== e_ok || r_field !== e_field
          || r_u !== e_u) begin
        n_err++;
        $display("FAIL rnd m=%0d v=%h got lat=%0d ok=%b f=%h u=%b exp lat=%0d ok=%b f=%h u=%b",
          m, v, r_lat, r_ok, r_field, r_u, e_lat, e_ok, e_field, e_u);
      end
      if (r_ok === 1'b1) begin
        n_vec++;
        if (decode(m, r_field, r_u) !== v) begin
          n_err++;
          $display("FAIL roundtrip m=%0d v=%h got %h exp %h",
            m, v, decode(m, r_field, r_u), v);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode00();
    test_mode01();
    test_mode10();
    test_mode11_and_hold();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    test_random(2'b00, 1000);
    test_random(2'b01, 1000);
    test_random(2'b10, 1000);
    test_random(2'b11, 200);
    $display("== %0d vectors applied, %0d miscompares ==",
      n_vec, n_err);
    $finish;
  end

endmodule
